// File: rtl/spi_reg_ctrlr.sv
// SPI command/register controller: decodes {cmd, data...} frames into a byte-addressed
// map of chip ID, synchronised switches and LEDs. Define AUTOINC_EN for burst auto-increment.
module spi_reg_ctrlr #(
  parameter int unsigned SW_W    = 16,
  parameter int unsigned LED_W   = 16,
  parameter logic [7:0]  CHIP_ID = 8'h07
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  input  logic             cs,
  input  logic             dvalid,
  input  logic [7:0]       din,
  output logic [7:0]       dout
);

  localparam int unsigned SW_BYTES  = (SW_W + 7) / 8;
  localparam int unsigned LED_BYTES = (LED_W + 7) / 8;
  localparam int unsigned SW_PW     = SW_BYTES * 8;
  localparam int unsigned LED_PW    = LED_BYTES * 8;
  localparam int unsigned LED_BASE  = SW_BYTES + 1;

  typedef enum logic {ST_CMD, ST_DATA} state_t;

  state_t             state, state_nxt;
  logic [6:0]         addr, addr_nxt;
  logic               rw, rw_nxt;
  logic               hold, hold_nxt;
  logic               dvalid_q;
  logic [SW_W-1:0]    sw_meta, sw_sync;
  logic [LED_W-1:0]   leds_nxt;
  logic [7:0]         dout_nxt;
  logic [SW_PW-1:0]   sw_pad;
  logic [LED_PW-1:0]  led_pad;
  logic               byte_ev_c;

  // Byte-wide read mux over the register map; unmapped addresses read zero.
  function automatic logic [7:0] reg_rd(input logic [6:0]        a,
                                        input logic [SW_PW-1:0]  sw_p,
                                        input logic [LED_PW-1:0] led_p);
    logic [7:0] r;
    r = 8'h00;
    if (a == 7'd0) r = CHIP_ID;
    for (int i = 0; i < int'(SW_BYTES); i++)
      if (a == 7'(i + 1)) r = sw_p[i*8 +: 8];
    for (int i = 0; i < int'(LED_BYTES); i++)
      if (a == 7'(int'(LED_BASE) + i)) r = led_p[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    sw_pad           = '0;
    sw_pad[SW_W-1:0] = sw_sync;
  end

  // hold blocks bytes of a frame interrupted by reset until cs drops
  assign byte_ev_c = !dvalid_q && dvalid && cs && !hold;

  always_comb begin
    state_nxt          = state;
    addr_nxt           = addr;
    rw_nxt             = rw;
    hold_nxt           = hold;
    dout_nxt           = dout;
    led_pad            = '0;
    led_pad[LED_W-1:0] = leds;
    if (!cs) begin
      state_nxt = ST_CMD;
      addr_nxt  = 7'd0;
      rw_nxt    = 1'b0;
      hold_nxt  = 1'b0;
      dout_nxt  = CHIP_ID;
    end else if (byte_ev_c) begin
      case (state)
        ST_CMD: begin
          rw_nxt    = din[7];
          addr_nxt  = din[6:0];
          state_nxt = ST_DATA;
          dout_nxt  = din[7] ? reg_rd(din[6:0], sw_pad, led_pad) : 8'h00;
        end
        ST_DATA: begin
          if (!rw)
            for (int i = 0; i < int'(LED_BYTES); i++)
              if (addr == 7'(int'(LED_BASE) + i)) led_pad[i*8 +: 8] = din;
`ifdef AUTOINC_EN
          addr_nxt = addr + 7'd1;
`else
          addr_nxt = addr;
`endif
          dout_nxt = rw ? reg_rd(addr_nxt, sw_pad, led_pad) : 8'h00;
        end
        default: state_nxt = ST_CMD;
      endcase
    end
    leds_nxt = led_pad[LED_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CMD;
      addr     <= 7'd0;
      rw       <= 1'b0;
      hold     <= 1'b1;
      dvalid_q <= 1'b0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      leds     <= '0;
      dout     <= CHIP_ID;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      rw       <= rw_nxt;
      hold     <= hold_nxt;
      dvalid_q <= dvalid;
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      leds     <= leds_nxt;
      dout     <= dout_nxt;
    end
  end

endmodule
